// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Multi-cycle control FSM for the RV32 core. It owns the PC and the
//   instruction register, sequences FETCH -> EXEC -> (MEM) -> (WB), and
//   handshakes with the instruction and data memories. BLT is resolved in
//   EXEC from branch_enable. A request left unanswered for MAX_WAIT cycles
//   parks the FSM in ERROR until reset.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 keep executing; sampled at instruction boundaries
//   imem_req/addr/ready/rdata   instruction fetch handshake
//   instr               instruction register
//   is_branch/load/store        decoder classification of instr
//   branch_enable/offset        branch unit result and immediate
//   dmem_req/ready      data memory handshake
//   rf_we               register-file write strobe (WB)
//   stage               00 FETCH/IDLE/ERROR, 01 EXEC, 10 MEM, 11 WB
//   pc                  program counter
//   retired             pulse in the cycle whose edge updates pc
//   timeout_err         sticky memory-timeout flag
module stage_sequencer #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              MAX_WAIT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr,
   input  logic            is_branch,
   input  logic            is_load,
   input  logic            is_store,
   input  logic            branch_enable,
   input  logic [XLEN-1:0] branch_offset,
   output logic            dmem_req,
   input  logic            dmem_ready,
   output logic            rf_we,
   output logic [1:0]      stage,
   output logic [XLEN-1:0] pc,
   output logic            retired,
   output logic            timeout_err
);

   localparam int              WCW        = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_ERROR
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [WCW-1:0]  wait_q, wait_d;
   logic            store_q, store_d;
   logic            err_q, err_d;
   logic            timeout_hit;
   state_e          next_st;
   logic [XLEN-1:0] pc_seq, pc_br;

   // The MAX_WAIT-th unanswered request cycle is the last one allowed.
   assign timeout_hit = (MAX_WAIT > 0) && (wait_q == WCW'(MAX_WAIT - 1));
   assign next_st     = run ? S_FETCH : S_IDLE;
   // pc[1:0] is forced to 00 on every update, including odd branch offsets.
   assign pc_seq      = (pc_q + XLEN'(4)) & ALIGN_MASK;
   assign pc_br       = (pc_q + branch_offset) & ALIGN_MASK;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         wait_q  <= '0;
         store_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         wait_q  <= wait_d;
         store_q <= store_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      wait_d   = '0;  // clears whenever a request completes or is not active
      store_d  = store_q;
      err_d    = err_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      rf_we    = 1'b0;
      retired  = 1'b0;
      stage    = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = S_EXEC;
            end else if (timeout_hit) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + WCW'(1);
            end
         end
         S_EXEC: begin
            stage = 2'b01;
            if (is_branch) begin
               pc_d    = branch_enable ? pc_br : pc_seq;
               retired = 1'b1;
               state_d = next_st;
            end else if (is_load || is_store) begin
               // Latched so MEM does not depend on decoder outputs; load+store acts as store.
               store_d = is_store;
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            stage    = 2'b10;
            dmem_req = 1'b1;
            if (dmem_ready) begin
               if (store_q) begin
                  pc_d    = pc_seq;
                  retired = 1'b1;
                  state_d = next_st;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout_hit) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + WCW'(1);
            end
         end
         S_WB: begin
            stage   = 2'b11;
            rf_we   = 1'b1;
            pc_d    = pc_seq;
            retired = 1'b1;
            state_d = next_st;
         end
         S_ERROR: begin
            err_d = 1'b1;
         end
         default: begin
            state_d = S_ERROR;
            err_d   = 1'b1;
         end
      endcase
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer. Each instruction is described by
// its class, fetch/data wait counts and branch inputs; the bench derives the
// expected per-cycle stage/strobe trace and the next PC from those rules.
module tb_stage_sequencer;
   localparam int MAXW = 16;

   logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0;
   logic        imem_ready = 1'b0, is_branch = 1'b0, is_load = 1'b0, is_store = 1'b0;
   logic        branch_enable = 1'b0, dmem_ready = 1'b0;
   logic [31:0] imem_rdata = '0, branch_offset = '0;
   logic        imem_req, dmem_req, rf_we, retired, timeout_err;
   logic [31:0] imem_addr, instr, pc;
   logic [1:0]  stage;

   int          n_chk = 0, n_fail = 0;
   logic [31:0] pc_m = '0;

   stage_sequencer #(.XLEN(32), .RESET_PC(32'h0), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instr(instr),
      .is_branch(is_branch), .is_load(is_load), .is_store(is_store),
      .branch_enable(branch_enable), .branch_offset(branch_offset),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .rf_we(rf_we),
      .stage(stage), .pc(pc), .retired(retired), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      run = 0; imem_ready = 0; dmem_ready = 0; is_branch = 0; is_load = 0;
      is_store = 0; branch_enable = 0; branch_offset = '0; imem_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      pc_m = 32'h0;
   endtask

   task automatic start_run();
      run = 1;
      @(posedge clk); #1;
   endtask

   // kind: 0 ALU, 1 BLT, 2 load, 3 store, 4 load+store (acts as store).
   // Entered in FETCH at posedge+1; leaves at posedge+1 after the retiring edge.
   task automatic run_instr(input int kind, input int fw, input int mw, input bit be,
                            input logic [31:0] off, input bit run_after);
      bit          mem, wb;
      int          n, phase;
      logic [31:0] rd, pc_n;
      logic [5:0]  exp_v, got_v;
      mem = (kind >= 2);
      wb  = (kind == 0) || (kind == 2);
      n   = fw + 2 + (mem ? mw + 1 : 0) + (wb ? 1 : 0);
      rd  = $urandom;
      imem_rdata    = rd;
      is_branch     = (kind == 1);
      is_load       = (kind == 2) || (kind == 4);
      is_store      = (kind == 3) || (kind == 4);
      branch_enable = be;
      branch_offset = off;
      pc_n = (kind == 1 && be) ? pc_m + off : pc_m + 32'd4;
      pc_n[1:0] = 2'b00;
      for (int i = 0; i < n; i++) begin
         if (i <= fw)                      phase = 0;
         else if (i == fw + 1)             phase = 1;
         else if (mem && i <= fw + 2 + mw) phase = 2;
         else                              phase = 3;
         // Ready lines outside their own request phase are random noise.
         imem_ready = (phase == 0) ? (i == fw) : 1'($urandom);
         dmem_ready = (phase == 2) ? (i == fw + 2 + mw) : 1'($urandom);
         run        = (i == n - 1) ? run_after : 1'($urandom);
         @(negedge clk);
         exp_v = {2'(phase), phase == 0, phase == 2, phase == 3, i == n - 1};
         got_v = {stage, imem_req, dmem_req, rf_we, retired};
         n_chk++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_outputs kind=%0d cyc=%0d {stage,ireq,dreq,we,ret}: got %b expected %b",
                     kind, i, got_v, exp_v);
         end
         n_chk++;
         if (pc !== pc_m || imem_addr !== pc_m) begin
            n_fail++;
            $display("FAIL pc_hold kind=%0d cyc=%0d: got pc=%h addr=%h expected %h",
                     kind, i, pc, imem_addr, pc_m);
         end
         @(posedge clk); #1;
      end
      pc_m = pc_n;
      n_chk++;
      if (pc !== pc_m) begin
         n_fail++;
         $display("FAIL pc_next kind=%0d: got %h expected %h", kind, pc, pc_m);
      end
      n_chk++;
      if (instr !== rd) begin
         n_fail++;
         $display("FAIL instr_reg kind=%0d: got %h expected %h", kind, instr, rd);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      imem_ready = 1; dmem_ready = 1;
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++;
      if ({stage, imem_req, dmem_req, rf_we, retired, timeout_err, pc, instr} !== {7'b0, 32'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_state: got stage=%b ireq=%b dreq=%b we=%b ret=%b err=%b pc=%h instr=%h expected all zero",
                  stage, imem_req, dmem_req, rf_we, retired, timeout_err, pc, instr);
      end
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_chk++;
         if ({stage, imem_req, dmem_req, rf_we, retired} !== 6'b0) begin
            n_fail++;
            $display("FAIL idle_run0 cyc=%0d: got %b expected 000000", i,
                     {stage, imem_req, dmem_req, rf_we, retired});
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      do_reset();
      start_run();
      run_instr(0, 0, 0, 0, 32'h0, 1);
      run_instr(0, 2, 0, 0, 32'h0, 1);
   endtask

   task automatic test_branch();
      do_reset();
      start_run();
      for (int i = 0; i < 4; i++) run_instr(0, 0, 0, 0, 32'h0, 1);  // pc = 0x10
      run_instr(1, 0, 0, 1, 32'hFFFF_FFF8, 1);                       // taken -> 0x08
      run_instr(0, 0, 0, 0, 32'h0, 1);
      run_instr(0, 0, 0, 0, 32'h0, 1);                               // pc = 0x10
      run_instr(1, 1, 0, 0, 32'hFFFF_FFF8, 1);                       // not taken -> 0x14
   endtask

   task automatic test_load_store();
      run_instr(2, 0, 3, 0, 32'h0, 1);
      run_instr(3, 1, 2, 0, 32'h0, 1);
      run_instr(4, 0, 0, 0, 32'h0, 1);
   endtask

   task automatic test_boundaries();
      run_instr(0, MAXW - 1, 0, 0, 32'h0, 1);   // ready on the last allowed cycle
      run_instr(2, MAXW - 1, MAXW - 1, 0, 32'h0, 1);
      run_instr(1, 0, 0, 1, 32'h0000_0013, 1);  // odd offset: low bits dropped
      run_instr(1, 0, 0, 1, 32'hFFFF_FFFC - pc_m, 1);
      run_instr(0, 0, 0, 0, 32'h0, 1);          // 0xFFFF_FFFC + 4 wraps to 0
   endtask

   task automatic test_stop();
      run_instr(0, 1, 0, 0, 32'h0, 0);
      imem_ready = 1; dmem_ready = 1; run = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_chk++;
         if ({stage, imem_req, dmem_req, rf_we, retired} !== 6'b0 || pc !== pc_m) begin
            n_fail++;
            $display("FAIL stop_idle cyc=%0d: got %b pc=%h expected 000000 pc=%h", i,
                     {stage, imem_req, dmem_req, rf_we, retired}, pc, pc_m);
         end
         @(posedge clk); #1;
      end
      start_run();
      run_instr(3, 0, 1, 0, 32'h0, 1);
   endtask

   task automatic test_random();
      int  kind, fw, mw;
      bit  ra;
      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(0, 4);
         fw   = $urandom_range(0, 4);
         mw   = $urandom_range(0, 4);
         ra   = ($urandom_range(0, 7) != 0);
         run_instr(kind, fw, mw, 1'($urandom), $urandom, ra);
         if (!ra) begin
            run = 0; imem_ready = 1;
            @(negedge clk);
            n_chk++;
            if ({stage, imem_req} !== 3'b0) begin
               n_fail++;
               $display("FAIL rand_idle k=%0d: got %b expected 000", k, {stage, imem_req});
            end
            @(posedge clk); #1;
            start_run();
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      start_run();
      run_instr(0, 0, 0, 0, 32'h0, 1);
      run_instr(0, 0, 0, 0, 32'h0, 1);                 // pc = 0x08
      is_load = 1; is_store = 0; is_branch = 0; imem_ready = 1; dmem_ready = 0;
      @(posedge clk); #1;                              // -> EXEC
      @(posedge clk); #1;                              // -> MEM
      imem_ready = 0;
      @(negedge clk);
      n_chk++;
      if ({stage, dmem_req} !== 3'b101 || pc !== 32'h8) begin
         n_fail++;
         $display("FAIL mid_mem_pre: got stage=%b dreq=%b pc=%h expected 10 1 00000008", stage, dmem_req, pc);
      end
      #2 rst_n = 0;
      #1;
      n_chk++;
      if ({stage, imem_req, dmem_req, rf_we, retired} !== 6'b0 || pc !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_mem_reset: got %b pc=%h expected 000000 pc=00000000",
                  {stage, imem_req, dmem_req, rf_we, retired}, pc);
      end
      @(posedge clk); #1;
      do_reset();
   endtask

   task automatic test_timeout(input bit in_mem);
      int cnt;
      do_reset();
      start_run();
      if (in_mem) begin
         is_load = 1; imem_ready = 1;
         @(posedge clk); #1;
         @(posedge clk); #1;
      end
      imem_ready = 0; dmem_ready = 0;
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 0) begin
            n_chk++;
            if (timeout_err !== 1'b0) begin
               n_fail++;
               $display("FAIL timeout_early mem=%0d: got %b expected 0", in_mem, timeout_err);
            end
         end
         if (in_mem ? dmem_req : imem_req) cnt++;
         else break;
         @(posedge clk); #1;
      end
      n_chk++;
      if (cnt != MAXW) begin
         n_fail++;
         $display("FAIL timeout_req_cycles mem=%0d: got %0d expected %0d", in_mem, cnt, MAXW);
      end
      imem_ready = 1; dmem_ready = 1; run = 1;
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if ({stage, imem_req, dmem_req, rf_we, retired, timeout_err} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL error_sticky mem=%0d cyc=%0d: got %b expected 0000001", in_mem, i,
                     {stage, imem_req, dmem_req, rf_we, retired, timeout_err});
         end
         @(negedge clk);
      end
      do_reset();
      @(negedge clk);
      n_chk++;
      if ({timeout_err, stage} !== 3'b0) begin
         n_fail++;
         $display("FAIL error_cleared mem=%0d: got %b expected 000", in_mem, {timeout_err, stage});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_load_store();
      test_boundaries();
      test_stop();
      test_random();
      test_mid_reset();
      test_timeout(0);
      test_timeout(1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
